// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between the RV32I MEM stage and a word-wide,
// variable-latency data memory with a req/ack handshake.
// Optional feature macro: LSU_MISALIGN_EN (split misaligned accesses into two
// word transfers instead of faulting).
module dmem_lsu #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mem_r,
  input  logic        cpu_mem_w,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_dmtype,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StDone} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q;
  logic [1:0]  off_q;
  logic [2:0]  type_q;
  logic        we_q;
  logic        split_q;
  logic        fault_q;
  logic [3:0]  be_hi_q;
  logic [31:0] data0_q;

  logic        req_any;
  logic        illegal;
  logic        split_req;
  logic        timeout;
  logic        accept;
  logic        go_acc1;
  logic        finish;
  logic        set_fault;
  logic [1:0]  off;
  logic [3:0]  be_base;
  logic [7:0]  be_mask;
  logic [31:0] rep_data;
  logic [31:0] lane_data;

  // Shift the byte pair down by the offset, then extend per funct3.
  function automatic logic [31:0] extract(input logic [63:0] pair, input logic [1:0] sh,
                                          input logic [2:0] typ);
    logic [31:0] w;
    w = 32'(pair >> {sh, 3'b000});
    case (typ[1:0])
      2'b00:   extract = typ[2] ? {24'h0, w[7:0]} : {{24{w[7]}}, w[7:0]};
      2'b01:   extract = typ[2] ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: extract = w;
    endcase
  endfunction

  // Decode the incoming request: enables, lane data, legality.
  always_comb begin
    off     = cpu_addr[1:0];
    req_any = cpu_mem_r | cpu_mem_w;
    case (cpu_dmtype[1:0])
      2'b00: begin
        be_base  = 4'b0001;
        rep_data = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        be_base  = 4'b0011;
        rep_data = {2{cpu_wdata[15:0]}};
      end
      default: begin
        be_base  = 4'b1111;
        rep_data = cpu_wdata;
      end
    endcase
    // Upper nibble holds the lanes that spill into the next word.
    be_mask   = {4'b0000, be_base} << off;
    split_req = |be_mask[7:4];
`ifdef LSU_MISALIGN_EN
    // Rotate so every enabled lane of either word carries its own byte.
    case (off)
      2'd0:    lane_data = rep_data;
      2'd1:    lane_data = {rep_data[23:0], rep_data[31:24]};
      2'd2:    lane_data = {rep_data[15:0], rep_data[31:16]};
      default: lane_data = {rep_data[7:0], rep_data[31:8]};
    endcase
`else
    lane_data = rep_data;
`endif
    illegal = (cpu_mem_r & cpu_mem_w) | (cpu_dmtype == 3'b011) | (cpu_dmtype[2:1] == 2'b11) |
              (cpu_mem_w & cpu_dmtype[2]);
`ifndef LSU_MISALIGN_EN
    illegal = illegal | split_req;
`endif
    timeout = (MAX_WAIT != 0) && ((cnt_q + 32'd1) == MAX_WAIT);
  end

  // Next-state logic and handshake/pipeline outputs.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    go_acc1   = 1'b0;
    finish    = 1'b0;
    set_fault = 1'b0;
    cpu_stall = 1'b0;
    cpu_fault = 1'b0;
    mem_req   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cpu_stall = req_any;
        if (req_any) begin
          if (illegal) begin
            state_d   = StDone;
            set_fault = 1'b1;
          end else begin
            state_d = StAcc0;
            accept  = 1'b1;
          end
        end
      end
      StAcc0: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        if (mem_ack) begin
          if (split_q) begin
            state_d = StAcc1;
            go_acc1 = 1'b1;
          end else begin
            state_d = StDone;
            finish  = 1'b1;
          end
        end else if (timeout) begin
          state_d   = StDone;
          set_fault = 1'b1;
        end
      end
      StAcc1: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        if (mem_ack) begin
          state_d = StDone;
          finish  = 1'b1;
        end else if (timeout) begin
          state_d   = StDone;
          set_fault = 1'b1;
        end
      end
      StDone: begin
        cpu_fault = fault_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (reset) begin
      cpu_stall = 1'b0;
    end
  end

  // State, latched request, memory-side drive and load result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      off_q     <= '0;
      type_q    <= '0;
      we_q      <= 1'b0;
      split_q   <= 1'b0;
      fault_q   <= 1'b0;
      be_hi_q   <= '0;
      data0_q   <= '0;
      cpu_rdata <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= set_fault;
      if (accept || go_acc1) begin
        cnt_q <= '0;
      end else if (mem_req) begin
        cnt_q <= cnt_q + 32'd1;
      end
      if (accept) begin
        off_q     <= off;
        type_q    <= cpu_dmtype;
        we_q      <= cpu_mem_w;
        split_q   <= split_req;
        be_hi_q   <= be_mask[7:4];
        mem_we    <= cpu_mem_w;
        mem_addr  <= {cpu_addr[31:2], 2'b00};
        mem_be    <= be_mask[3:0];
        mem_wdata <= lane_data;
      end
      if (go_acc1) begin
        data0_q  <= mem_rdata;
        mem_addr <= mem_addr + 32'd4;
        mem_be   <= be_hi_q;
      end
      if (finish && !we_q) begin
        cpu_rdata <= extract((state_q == StAcc1) ? {mem_rdata, data0_q} : {32'h0, mem_rdata},
                             off_q, type_q);
      end
    end
  end

endmodule
